// File: rtl/inv_subbytes_seq.sv
// Multi-cycle AES InvSubBytes engine: BYTES_PER_CYCLE inverse-S-box lanes walk the
// captured 128-bit state in ascending byte order, then hold the result for output.
module inv_subbytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int NGROUPS = 16 / BYTES_PER_CYCLE;
    localparam int CW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NGROUPS - 1);

    generate
        if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
            BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
            $error("inv_subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [127:0]    src_q, src_d;
    logic [127:0]    res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Subfield inversion: x^-1 = (x^17)^-1 * x^16, where the norm x^17 lies in GF(2^4)
    // and is inverted there as n^14; zero falls through to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, n, n2, n4, n8, ninv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        n    = gf_mul(x16, x);
        n2   = gf_mul(n, n);
        n4   = gf_mul(n2, n2);
        n8   = gf_mul(n4, n4);
        ninv = gf_mul(gf_mul(n2, n4), n8);
        return gf_mul(ninv, x16);
    endfunction

    // Inverse affine map (rotations left by 1, 3 and 6, then ^0x05) ahead of inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    logic [7:0] lane_in  [BYTES_PER_CYCLE];
    logic [7:0] lane_out [BYTES_PER_CYCLE];

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lane
            assign lane_in[gi]  = src_q[(int'(cnt_q) * BYTES_PER_CYCLE + gi) * 8 +: 8];
            assign lane_out[gi] = inv_sbox(lane_in[gi]);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                    res_d[(int'(cnt_q) * BYTES_PER_CYCLE + k) * 8 +: 8] = lane_out[k];
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = res_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Bench for inv_subbytes_seq: one instance per lane count (1,2,4,8,16), checked against an
// inverse S-box derived by inverting a brute-force forward S-box.
`timescale 1ns/1ps
module tb_inv_subbytes_seq;
    localparam int NI = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0]  in_data  [NI];
    logic [127:0]  out_data [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            inv_subbytes_seq #(.BYTES_PER_CYCLE(1 << gi)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid[gi]),
                .in_ready (in_ready[gi]),
                .in_data  (in_data[gi]),
                .out_valid(out_valid[gi]),
                .out_ready(out_ready[gi]),
                .out_data (out_data[gi]),
                .busy     (busy[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t         vecs [6];
    logic [127:0] exp_q [$];
    logic [7:0]   inv_tbl [256];
    int           n_checks = 0;
    int           n_pass   = 0;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Forward S-box by exhaustive inverse search, then invert the permutation.
    task automatic build_model();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tbl[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] exp_state(input logic [127:0] d);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[d[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Drive one state through instance idx; returns with out_valid seen and data compared.
    task automatic run_txn(input int idx, input logic [127:0] din, input logic [127:0] req,
                           input string tag);
        int           lat;
        int           wait_c;
        logic [127:0] got;
        logic [127:0] want;
        exp_q.push_back(req);
        in_data[idx]  = din;
        in_valid[idx] = 1'b1;
        wait_c = 0;
        while (!in_ready[idx] && wait_c < 50) begin
            @(posedge clk); #1;
            wait_c++;
        end
        if (!in_ready[idx]) begin
            chk({tag, " accept timeout in_ready"}, 128'(in_ready[idx]), 128'(1));
            want = exp_q.pop_front();
            in_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        in_data[idx]  = ~din;
        lat = 1;
        while (!out_valid[idx] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 128'(lat), 128'(16 / (1 << idx) + 1));
        got  = out_data[idx];
        want = exp_q.pop_front();
        chk({tag, " data"}, got, want);
        $display("txn %s B=%0d in=%h out=%h lat=%0d", tag, 1 << idx, din, got, lat);
    endtask

    task automatic do_txn(input int idx, input logic [127:0] din, input logic [127:0] req,
                          input string tag);
        run_txn(idx, din, req, tag);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] din;
        logic [127:0] held;
        logic [127:0] d2;
        int           bad_ov, bad_od, bad_ir, stale;

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        for (int i = 0; i < NI; i++) in_data[i] = '0;
        build_model();

        vecs[0] = '{128'h0, {16{8'h52}}};
        vecs[1] = '{{16{8'h63}}, 128'h0};
        vecs[2] = '{{16{8'h16}}, {16{8'hFF}}};
        vecs[3] = '{{16{8'hED}}, {16{8'h53}}};
        vecs[4] = '{{16{8'h7C}}, {16{8'h01}}};
        vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};

        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset out_valid B=%0d", 1 << i), 128'(out_valid[i]), 128'(0));
            chk($sformatf("reset busy B=%0d", 1 << i), 128'(busy[i]), 128'(0));
            chk($sformatf("reset out_data B=%0d", 1 << i), out_data[i], 128'h0);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++)
            chk($sformatf("in_ready after reset B=%0d", 1 << i), 128'(in_ready[i]), 128'(1));

        for (int v = 0; v < 6; v++)
            do_txn(2, vecs[v].din, vecs[v].dout, $sformatf("vec%0d", v));

        for (int idx = 0; idx < NI; idx++) begin
            for (int j = 0; j < 16; j++) begin
                for (int i = 0; i < 16; i++) din[8*i +: 8] = 8'(16 * j + i);
                do_txn(idx, din, exp_state(din), $sformatf("exh j=%0d", j));
            end
        end

        // Back-pressure with a new request waiting upstream.
        out_ready[2] = 1'b0;
        din = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        d2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        run_txn(2, din, exp_state(din), "bp");
        held = out_data[2];
        in_data[2]  = d2;
        in_valid[2] = 1'b1;
        bad_ov = 0; bad_od = 0; bad_ir = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid[2]) bad_ov++;
            if (out_data[2] !== held) bad_od++;
            if (in_ready[2]) bad_ir++;
        end
        chk("bp cycles with out_valid low", 128'(bad_ov), 128'(0));
        chk("bp cycles with out_data changed", 128'(bad_od), 128'(0));
        chk("bp cycles with in_ready high", 128'(bad_ir), 128'(0));
        out_ready[2] = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", 128'(in_ready[2]), 128'(1));
        chk("bp release out_valid", 128'(out_valid[2]), 128'(0));
        do_txn(2, d2, exp_state(d2), "bp queued");

        // Reset asserted mid-cycle while holding a result in DONE.
        out_ready[2] = 1'b0;
        run_txn(2, 128'h0, {16{8'h52}}, "pre-reset");
        #3 rst = 1'b1;
        #1;
        chk("reset in DONE out_valid", 128'(out_valid[2]), 128'(0));
        chk("reset in DONE busy", 128'(busy[2]), 128'(0));
        chk("reset in DONE out_data", out_data[2], 128'h0);
        #2 rst = 1'b0;
        out_ready[2] = 1'b1;
        @(posedge clk); #1;
        chk("reset in DONE in_ready", 128'(in_ready[2]), 128'(1));

        // Reset during RUN at cnt=2.
        in_data[2]  = 128'h0;
        in_valid[2] = 1'b1;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("run busy before reset", 128'(busy[2]), 128'(1));
        rst = 1'b1;
        #1;
        chk("reset in RUN out_valid", 128'(out_valid[2]), 128'(0));
        chk("reset in RUN busy", 128'(busy[2]), 128'(0));
        chk("reset in RUN out_data", out_data[2], 128'h0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        stale = 0;
        repeat (8) begin
            if (out_valid[2]) stale++;
            @(posedge clk); #1;
        end
        chk("stale out_valid cycles after reset", 128'(stale), 128'(0));
        din = 128'h00112233445566778899aabbccddeeff;
        do_txn(2, din, exp_state(din), "after run reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
